// File: rtl/matmul_sequencer_pkg.sv
// Shared definitions for the 3x3 matrix multiply sequencer.
// Holds the default widths, the FSM state encoding and the job length constants.
package matmul_sequencer_pkg;

    localparam int DEFAULT_ENTRY_SIZE    = 5;
    localparam int DEFAULT_RESENTRY_SIZE = 9;

    localparam int JOB_FULL   = 18;
    localparam int JOB_A_ONLY = 9;
    localparam int RES_COUNT  = 9;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUT     = 2'd2
    } state_t;

endpackage

// File: rtl/matmul_sequencer_mult.sv
// Combinational 3x3 unsigned matrix multiplier; rows are packed with column 0 in the MSBs.
// Each result entry is reduced modulo 2^RESENTRY_SIZE.
module matrixmultiplication3by3
    import matmul_sequencer_pkg::*;
#(
    parameter int ENTRY_SIZE    = DEFAULT_ENTRY_SIZE,
    parameter int RESENTRY_SIZE = DEFAULT_RESENTRY_SIZE
) (
    input  logic [3*ENTRY_SIZE-1:0]    a_row0,
    input  logic [3*ENTRY_SIZE-1:0]    a_row1,
    input  logic [3*ENTRY_SIZE-1:0]    a_row2,
    input  logic [3*ENTRY_SIZE-1:0]    b_row0,
    input  logic [3*ENTRY_SIZE-1:0]    b_row1,
    input  logic [3*ENTRY_SIZE-1:0]    b_row2,
    output logic [3*RESENTRY_SIZE-1:0] c_row0,
    output logic [3*RESENTRY_SIZE-1:0] c_row1,
    output logic [3*RESENTRY_SIZE-1:0] c_row2
);

    // Accumulator wide enough for three full products, and never narrower than the result.
    localparam int ACC_W = (2*ENTRY_SIZE+2 > RESENTRY_SIZE) ? 2*ENTRY_SIZE+2 : RESENTRY_SIZE;

    logic [3*ENTRY_SIZE-1:0]  a_rows [3];
    logic [3*ENTRY_SIZE-1:0]  b_rows [3];
    logic [RESENTRY_SIZE-1:0] c_ent  [3][3];
    logic [ACC_W-1:0]         acc;

    assign a_rows[0] = a_row0;
    assign a_rows[1] = a_row1;
    assign a_rows[2] = a_row2;
    assign b_rows[0] = b_row0;
    assign b_rows[1] = b_row1;
    assign b_rows[2] = b_row2;

    always_comb begin
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = '0;
                for (int k = 0; k < 3; k++) begin
                    acc = acc + ACC_W'(a_rows[i][(2-k)*ENTRY_SIZE +: ENTRY_SIZE])
                              * ACC_W'(b_rows[k][(2-j)*ENTRY_SIZE +: ENTRY_SIZE]);
                end
                c_ent[i][j] = acc[RESENTRY_SIZE-1:0];
            end
        end
    end

    assign c_row0 = {c_ent[0][0], c_ent[0][1], c_ent[0][2]};
    assign c_row1 = {c_ent[1][0], c_ent[1][1], c_ent[1][2]};
    assign c_row2 = {c_ent[2][0], c_ent[2][1], c_ent[2][2]};

endmodule

// File: rtl/matmul_sequencer.sv
// Streams A and B in over valid/ready, runs one 3x3 multiply per job and streams C out.
// B-reuse mode lets a job carry only A when a B matrix is already held.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int ENTRY_SIZE    = DEFAULT_ENTRY_SIZE,
    parameter int RESENTRY_SIZE = DEFAULT_RESENTRY_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ENTRY_SIZE-1:0]    in_data,
    input  logic                     reuse_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RESENTRY_SIZE-1:0] out_data,
    output logic                     out_last,
    output logic                     busy
);

    state_t state, next_state;

    logic [4:0] in_cnt;
    logic [3:0] out_cnt;
    logic       b_loaded;
    logic       reuse_mode;

    logic [ENTRY_SIZE-1:0]    a_mat [9];
    logic [ENTRY_SIZE-1:0]    b_mat [9];
    logic [RESENTRY_SIZE-1:0] c_mat [9];

    logic [3*ENTRY_SIZE-1:0]    a_rows [3];
    logic [3*ENTRY_SIZE-1:0]    b_rows [3];
    logic [3*RESENTRY_SIZE-1:0] c_rows [3];

    logic       in_fire, out_fire, eff_reuse, last_in, last_out;
    logic [4:0] job_len;
    logic [4:0] b_off;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    // Mode is decided on the first entry; a reuse request without a stored B falls back to a full job.
    assign eff_reuse = (in_cnt == 5'd0) ? (reuse_b & b_loaded) : reuse_mode;
    assign job_len   = eff_reuse ? 5'(JOB_A_ONLY) : 5'(JOB_FULL);
    assign last_in   = in_fire && (in_cnt == job_len - 5'd1);
    assign last_out  = out_fire && (out_cnt == 4'(RES_COUNT - 1));
    assign b_off     = in_cnt - 5'd9;

    for (genvar r = 0; r < 3; r++) begin : g_pack
        assign a_rows[r] = {a_mat[3*r], a_mat[3*r+1], a_mat[3*r+2]};
        assign b_rows[r] = {b_mat[3*r], b_mat[3*r+1], b_mat[3*r+2]};
    end

    matrixmultiplication3by3 #(
        .ENTRY_SIZE   (ENTRY_SIZE),
        .RESENTRY_SIZE(RESENTRY_SIZE)
    ) u_mult (
        .a_row0(a_rows[0]),
        .a_row1(a_rows[1]),
        .a_row2(a_rows[2]),
        .b_row0(b_rows[0]),
        .b_row1(b_rows[1]),
        .b_row2(b_rows[2]),
        .c_row0(c_rows[0]),
        .c_row1(c_rows[1]),
        .c_row2(c_rows[2])
    );

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (last_in)  next_state = COMPUTE;
            COMPUTE:               next_state = OUT;
            OUT:     if (last_out) next_state = LOAD;
            default:               next_state = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == OUT);
        out_last  = out_valid && (out_cnt == 4'(RES_COUNT - 1));
        out_data  = out_valid ? c_mat[out_cnt] : '0;
        busy      = !((state == LOAD) && (in_cnt == 5'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            b_loaded   <= 1'b0;
            reuse_mode <= 1'b0;
        end else begin
            if (in_fire) begin
                in_cnt <= last_in ? 5'd0 : in_cnt + 5'd1;
                if (in_cnt == 5'd0) reuse_mode <= eff_reuse;
                if (last_in && !eff_reuse) b_loaded <= 1'b1;
            end
            if (state == COMPUTE) out_cnt <= '0;
            else if (out_fire)    out_cnt <= out_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                a_mat[i] <= '0;
                b_mat[i] <= '0;
                c_mat[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                if (in_cnt < 5'd9) a_mat[in_cnt[3:0]] <= in_data;
                else               b_mat[b_off[3:0]]  <= in_data;
            end
            if (state == COMPUTE) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        c_mat[3*r+c] <= c_rows[r][(2-c)*RESENTRY_SIZE +: RESENTRY_SIZE];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: directed jobs from the test plan plus randomized jobs,
// expected results computed from plain matrix arithmetic on the bench's own copies of A and B.
module tb_matmul_sequencer;

    localparam int E = 5;
    localparam int R = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [E-1:0] in_data;
    logic         reuse_b;
    logic         out_valid;
    logic         out_ready;
    logic [R-1:0] out_data;
    logic         out_last;
    logic         busy;

    matmul_sequencer #(.ENTRY_SIZE(E), .RESENTRY_SIZE(R)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .reuse_b  (reuse_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ja[9];
    int   jb[9];
    int   bmod[9];
    bit   model_bl = 1'b0;
    int   rdy_mode = 0;
    bit   gap_en = 1'b0;
    int   last_in_cycle = 0;
    int   xfer_count = 0;
    int   first_xfer = 0;
    int   last_xfer = 0;

    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [R-1:0] pd = '0;
    logic         pl = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and watches hold/latency rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !pv) check("latency", cyc - last_in_cycle, 2);
            if (pv && !pr) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), int'(pd));
                check("hold_last", int'(out_last), int'(pl));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0d required=none", out_data);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("out_data", int'(out_data), e_cur.data);
                    check("out_last", int'(out_last), int'(e_cur.last));
                end
                xfer_count++;
                if (xfer_count == 1) first_xfer = cyc;
                last_xfer = cyc;
            end
        end
        pv <= reset ? 1'b0 : out_valid;
        pr <= out_ready;
        pd <= out_data;
        pl <= out_last;
    end

    task automatic send(input int d, input bit rb);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d[E-1:0];
        reuse_b  = rb;
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        last_in_cycle = cyc;
        @(posedge clk);
    endtask

    task automatic maybe_gap();
        if (gap_en && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = E'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic run_job(input bit rb);
        bit eff;
        int s;
        eff = rb && model_bl;
        for (int k = 0; k < 9; k++) begin
            send(ja[k], (k == 0) ? rb : 1'($urandom_range(0, 1)));
            if (k == 0) begin
                #1;
                check("busy_in_job", int'(busy), 1);
            end
            if (k < 8 || !eff) maybe_gap();
        end
        if (!eff) begin
            #1;
            check("in_ready_mid_full_job", int'(in_ready), 1);
            for (int k = 0; k < 9; k++) begin
                send(jb[k], 1'($urandom_range(0, 1)));
                bmod[k] = jb[k];
                if (k < 8) maybe_gap();
            end
            model_bl = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += ja[i*3+k] * bmod[k*3+j];
                exp_q.push_back('{data: s % 512, last: (i == 2 && j == 2)});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_after_last", int'(in_ready), 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_busy", int'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_bl = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_identity(input int scale);
        for (int k = 0; k < 9; k++) ja[k] = (k % 4 == 0) ? scale : 0;
    endtask

    task automatic set_b_ref();
        jb = '{1, 2, 3, 2, 3, 5, 3, 1, 2};
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        reuse_b  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;

        set_identity(1);
        set_b_ref();
        run_job(1'b0);
        drain();

        set_identity(2);
        run_job(1'b1);
        drain();

        ja = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        jb = '{0, 0, 0, 0, 0, 0, 0, 2, 1};
        run_job(1'b0);
        drain();

        do_reset();
        set_identity(1);
        set_b_ref();
        run_job(1'b1);
        drain();

        rdy_mode = 1;
        xfer_count = 0;
        for (int k = 0; k < 9; k++) begin
            ja[k] = 31;
            jb[k] = 31;
        end
        run_job(1'b0);
        drain();
        check("toggle_xfers", xfer_count, 9);
        check("toggle_span", last_xfer - first_xfer, 16);
        rdy_mode = 0;

        for (int k = 0; k < 5; k++) send(k + 7, 1'b0);
        do_reset();
        set_identity(1);
        set_b_ref();
        run_job(1'b0);
        drain();

        rdy_mode = 2;
        gap_en   = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 9; k++) begin
                ja[k] = $urandom_range(0, 31);
                jb[k] = $urandom_range(0, 31);
            end
            run_job(1'($urandom_range(0, 1)));
            drain();
        end
        rdy_mode = 0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Streaming front-end and controller for the combinational 3x3 matrix multiplier (matrixmultiplication3by3). Accepts matrix entries serially over a valid/ready input port and assembles A and B in registers. Fires one multiply per job, registers C, and streams the 9 result entries out over a valid/ready output port. An optional B-reuse mode lets consecutive jobs share one B matrix.

Parameters:
ENTRY_SIZE, 5, width of one input matrix entry (unsigned)
RESENTRY_SIZE, 9, width of one result entry (unsigned, modulo 2^RESENTRY_SIZE)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a valid entry
in_ready  output  1  sequencer accepts an entry this cycle
in_data  input  ENTRY_SIZE  matrix entry, row-major order: A[0][0]..A[2][2], then B[0][0]..B[2][2]
reuse_b  input  1  sampled on the first accepted entry of a job; 1 = job carries A only and reuses the stored B
out_valid  output  1  out_data holds a valid result entry
out_ready  input  1  downstream accepts out_data
out_data  output  RESENTRY_SIZE  result entry, row-major C[0][0]..C[2][2]
out_last  output  1  high with out_valid on C[2][2]
busy  output  1  high in every state except LOAD with zero entries accepted

Behaviour:
- Reset: state LOAD, in_cnt=0, out_cnt=0, b_loaded=0. Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0. A/B/C registers are cleared to 0.
- Handshakes: an input transfer happens on a rising edge with in_valid&in_ready. An output transfer happens on a rising edge with out_valid&out_ready. out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Entry k (0..8) of a matrix maps to row k/3, col k%3.
- Row vector packing to the multiplier: row r = {M[r][0], M[r][1], M[r][2]}, with column 0 in the MSBs.
- Result entries are taken from the multiplier outputs in the same packing.
- State LOAD:
  - in_ready=1.
  - Job length is 9 entries if reuse_b is sampled 1 and b_loaded=1; otherwise 18.
  - reuse_b=1 with b_loaded=0 is treated as 0.
  - The effective mode is latched at in_cnt==0 and held for the job.
  - Entries 0..8 are written to A; entries 9..17 are written to B.
  - On the last transfer of the job: set b_loaded=1 if B was written, then go to COMPUTE.
- State COMPUTE (exactly 1 cycle):
  - in_ready=0.
  - The multiplier outputs are registered into C.
  - Next state is OUT with out_cnt=0.
- State OUT:
  - in_ready=0, out_valid=1, out_data=C[out_cnt].
  - out_last=1 when out_cnt==8.
  - Each output transfer increments out_cnt.
  - A transfer at out_cnt==8 returns to LOAD with in_cnt=0 and out_valid=0 on the next cycle.
- Latency: out_valid rises 2 cycles after the rising edge that accepts the final input entry. With out_ready held at 1, the 9 outputs occupy 9 consecutive cycles.
- Throughput: one job every (job length + 1 + 9) cycles when no stalls occur.
- Arithmetic:
  - C[i][j] = sum over k of A[i][k]*B[k][j], reduced mod 2^RESENTRY_SIZE.
  - Truncation is performed by the multiplier; the sequencer adds no saturation.
- in_valid while in_ready=0 is ignored; nothing is buffered or lost-counted.
- reset asserted mid-LOAD, COMPUTE or OUT aborts the job on that edge.
  - Partial entries and b_loaded are discarded.
  - The next job must be 18 entries.
- in_data is don't-care when in_valid=0.

Decomposition:
- Shared package: ENTRY_SIZE and RESENTRY_SIZE defaults, state encoding (LOAD=2'd0, COMPUTE=2'd1, OUT=2'd2), and the constants JOB_FULL=18, JOB_A_ONLY=9, RES_COUNT=9.
- One sub-module: an instance of matrixmultiplication3by3, fed from the A/B registers.
- Counters, FSM, and the C register file stay in matmul_sequencer.

Test Plan:
- Identity A, B={1,2,3;2,3,5;3,1,2}, 18 entries back-to-back, out_ready=1:
  - Outputs are 1,2,3,2,3,5,3,1,2.
  - out_valid rises 2 cycles after the last input.
  - out_last is high only on the 9th output.
- Zero A, B={0,0,0;0,0,0;0,2,1}: 9 outputs, all 0, then in_ready=1 and busy=0.
- After the identity job, send a job with reuse_b=1 and A=2*identity (9 entries only):
  - in_ready drops after the 9th entry.
  - Outputs are 2,4,6,4,6,10,6,2,4.
- reuse_b=1 immediately after reset, A=identity, B as in the first test: 18 entries are accepted and the identity outputs match the first test.
- All entries 31, out_ready toggling 1/0 each cycle:
  - Every output is 2883 mod 512 = 323.
  - out_data is held while out_ready=0.
  - Exactly 9 transfers occur, spanning about 17 cycles.
- Reset after 5 accepted entries, then a full identity/B job: correct identity outputs, with no stale data from the aborted job.
